// File: rtl/block_loader.sv
// Packs a stream of BWIDTH-bit words into one flat frame of NUMBLOCKS words for the absorb stage.
// Optional feature macro: BLOCK_LOADER_BYTE_MASK_EN (zero the unused bytes of a last word).
module block_loader #(
  parameter int BWIDTH    = 32,
  parameter int NUMBLOCKS = 12
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic [BWIDTH-1:0]                        in_data,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic                                     in_last,
  input  logic [$clog2(BWIDTH/8):0]                in_bytes,
  output logic [BWIDTH*NUMBLOCKS-1:0]              blocks,
  output logic                                     blk_valid,
  input  logic                                     blk_ack,
  output logic                                     finalize,
  output logic [$clog2(NUMBLOCKS):0]               word_count,
  output logic [$clog2(NUMBLOCKS*BWIDTH/8):0]      byte_count
);

  localparam int BPW  = BWIDTH / 8;
  localparam int BN_W = $clog2(BPW) + 1;
  localparam int WC_W = $clog2(NUMBLOCKS) + 1;
  localparam int BC_W = $clog2(NUMBLOCKS * BPW) + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FILL    = 2'd1,
    S_PRESENT = 2'd2,
    S_CLEAR   = 2'd3
  } state_t;

  state_t                     r_state;
  state_t                     w_state_next;
  logic                       r_in_ready;
  logic                       r_blk_valid;
  logic                       r_ack_armed;
  logic                       r_finalize;
  logic [BWIDTH*NUMBLOCKS-1:0] r_blocks;
  logic [WC_W-1:0]            r_word_count;
  logic [BC_W-1:0]            r_byte_count;
  logic                       w_accept;
  logic [BN_W-1:0]            w_nbytes;
  logic [BN_W-1:0]            w_inc;
  logic [BWIDTH-1:0]          w_word;

  assign w_accept = (r_state == S_FILL) && r_in_ready && in_valid;

  // Byte count of the incoming word; out-of-range last-word counts read as a full word.
  always_comb begin
    w_nbytes = in_bytes;
    if ((in_bytes == {BN_W{1'b0}}) || (in_bytes > BN_W'(BPW))) begin
      w_nbytes = BN_W'(BPW);
    end else begin
      w_nbytes = in_bytes;
    end
    if (in_last) begin
      w_inc = w_nbytes;
    end else begin
      w_inc = BN_W'(BPW);
    end
  end

  // Word as stored, optionally with the bytes past the end of the message zeroed.
  always_comb begin
    w_word = in_data;
`ifdef BLOCK_LOADER_BYTE_MASK_EN
    for (int b = 0; b < BPW; b++) begin
      if (in_last && (BN_W'(b) >= w_nbytes)) begin
        w_word[b*8 +: 8] = 8'h00;
      end else begin
        w_word[b*8 +: 8] = in_data[b*8 +: 8];
      end
    end
`endif
  end

  // Next-state logic; ack is only honoured once the frame has been presented for a full cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: w_state_next = S_FILL;
      S_FILL: begin
        if (w_accept && (in_last || (r_word_count == WC_W'(NUMBLOCKS - 1)))) begin
          w_state_next = S_PRESENT;
        end else begin
          w_state_next = S_FILL;
        end
      end
      S_PRESENT: begin
        if (r_ack_armed && blk_ack) begin
          w_state_next = S_CLEAR;
        end else begin
          w_state_next = S_PRESENT;
        end
      end
      S_CLEAR: w_state_next = S_FILL;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register and registered handshake outputs derived from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_blk_valid <= 1'b0;
      r_ack_armed <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_in_ready  <= (w_state_next == S_FILL);
      r_blk_valid <= (w_state_next == S_PRESENT);
      r_ack_armed <= (r_state == S_PRESENT) && (w_state_next == S_PRESENT);
    end
  end

  // Frame buffer and counters; zeroed on entry to CLEAR so the cleared frame is visible there.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blocks     <= '0;
      r_word_count <= {WC_W{1'b0}};
      r_byte_count <= {BC_W{1'b0}};
      r_finalize   <= 1'b0;
    end else if (w_state_next == S_CLEAR) begin
      r_blocks     <= '0;
      r_word_count <= {WC_W{1'b0}};
      r_byte_count <= {BC_W{1'b0}};
      r_finalize   <= 1'b0;
    end else if (w_accept) begin
      for (int k = 0; k < NUMBLOCKS; k++) begin
        if (WC_W'(k) == r_word_count) begin
          r_blocks[k*BWIDTH +: BWIDTH] <= w_word;
        end
      end
      r_word_count <= r_word_count + WC_W'(1);
      r_byte_count <= r_byte_count + BC_W'(w_inc);
      r_finalize   <= in_last;
    end
  end

  assign in_ready   = r_in_ready;
  assign blk_valid  = r_blk_valid;
  assign blocks     = r_blocks;
  assign finalize   = r_finalize;
  assign word_count = r_word_count;
  assign byte_count = r_byte_count;

endmodule

// File: tb/tb_block_loader.sv
// Directed self-checking bench for block_loader (BWIDTH=32, NUMBLOCKS=12).
module tb_block_loader;

  logic         clk;
  logic         reset_n;
  logic [31:0]  in_data;
  logic         in_valid;
  logic         in_ready;
  logic         in_last;
  logic [2:0]   in_bytes;
  logic [383:0] blocks;
  logic         blk_valid;
  logic         blk_ack;
  logic         finalize;
  logic [4:0]   word_count;
  logic [6:0]   byte_count;

  int checks = 0;
  int errors = 0;

  block_loader #(.BWIDTH(32), .NUMBLOCKS(12)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .in_bytes(in_bytes),
    .blocks(blocks), .blk_valid(blk_valid), .blk_ack(blk_ack),
    .finalize(finalize), .word_count(word_count), .byte_count(byte_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge; returns at the negedge following the accepting posedge.
  task automatic send_word(input logic [31:0] d, input logic l, input logic [2:0] b);
    int t;
    t = 0;
    in_data = d; in_valid = 1'b1; in_last = l; in_bytes = b;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 50) begin
      errors++;
      $display("FAIL send_timeout: in_ready got %0b want 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int t;
    t = 0;
    while (!in_ready && t < 4) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s: in_ready got %0b want 1", name, in_ready);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_bytes = 3'd0;
    in_data = 32'h0; blk_ack = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, blk_valid, finalize, word_count, byte_count} !== 15'h0 || blocks !== 384'h0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%0b vld=%0b fin=%0b wc=%0d bc=%0d want all 0",
               in_ready, blk_valid, finalize, word_count, byte_count);
    end
    reset_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL release_ready_low: got %0b want 0", in_ready);
    end
    @(negedge clk);
    wait_ready("release_ready_rise");
  endtask

  task automatic test_full_frame_and_ack();
    for (int i = 1; i <= 12; i++) begin
      if (i == 12) blk_ack = 1'b1;
      send_word(32'(i), 1'b0, 3'd0);
      if (i == 11) begin
        checks++;
        if (blk_valid !== 1'b0 || word_count !== 5'd11 || byte_count !== 7'd44) begin
          errors++;
          $display("FAIL full_partial: got vld=%0b wc=%0d bc=%0d want 0 11 44", blk_valid, word_count, byte_count);
        end
      end
    end
    checks++;
    if (blk_valid !== 1'b1 || in_ready !== 1'b0 || word_count !== 5'd12 || byte_count !== 7'd48 || finalize !== 1'b0) begin
      errors++;
      $display("FAIL full_present: got vld=%0b rdy=%0b wc=%0d bc=%0d fin=%0b want 1 0 12 48 0",
               blk_valid, in_ready, word_count, byte_count, finalize);
    end
    checks++;
    if (blocks[31:0] !== 32'h1 || blocks[383:352] !== 32'hC || blocks[191:160] !== 32'h6) begin
      errors++;
      $display("FAIL full_blocks: got w0=%h w5=%h w11=%h want 1 6 c", blocks[31:0], blocks[191:160], blocks[383:352]);
    end
    @(negedge clk);
    checks++;
    if (blk_valid !== 1'b1) begin
      errors++;
      $display("FAIL ack_first_cycle_ignored: blk_valid got %0b want 1", blk_valid);
    end
    @(negedge clk);
    checks++;
    if (blk_valid !== 1'b0 || in_ready !== 1'b0 || blocks !== 384'h0) begin
      errors++;
      $display("FAIL ack_clear: got vld=%0b rdy=%0b blocks_nz=%0b want 0 0 0", blk_valid, in_ready, |blocks);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || word_count !== 5'd0 || byte_count !== 7'd0) begin
      errors++;
      $display("FAIL ack_ready_return: got rdy=%0b wc=%0d bc=%0d want 1 0 0", in_ready, word_count, byte_count);
    end
    blk_ack = 1'b0;
  endtask

  task automatic test_short_frame_backpressure();
    logic [31:0] exp_last;
`ifdef BLOCK_LOADER_BYTE_MASK_EN
    exp_last = 32'h0000CCDD;
`else
    exp_last = 32'hAABBCCDD;
`endif
    send_word(32'h11111111, 1'b0, 3'd0);
    send_word(32'h22222222, 1'b0, 3'd0);
    send_word(32'hAABBCCDD, 1'b1, 3'd2);
    checks++;
    if (blk_valid !== 1'b1 || finalize !== 1'b1 || word_count !== 5'd3 || byte_count !== 7'd10) begin
      errors++;
      $display("FAIL short_counts: got vld=%0b fin=%0b wc=%0d bc=%0d want 1 1 3 10",
               blk_valid, finalize, word_count, byte_count);
    end
    checks++;
    if (blocks[95:64] !== exp_last || blocks[63:32] !== 32'h22222222 || blocks[383:96] !== 288'h0) begin
      errors++;
      $display("FAIL short_blocks: got w2=%h w1=%h upper_nz=%0b want %h 22222222 0",
               blocks[95:64], blocks[63:32], |blocks[383:96], exp_last);
    end
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 32'hBAD00000 + 32'(i); in_last = 1'(i & 1);
      @(negedge clk);
      checks++;
      if (word_count !== 5'd3 || byte_count !== 7'd10 || in_ready !== 1'b0 || blk_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_present_%0d: got wc=%0d bc=%0d rdy=%0b vld=%0b want 3 10 0 1",
                 i, word_count, byte_count, in_ready, blk_valid);
      end
    end
    blk_ack = 1'b1;
    @(negedge clk);
    in_data = 32'hBAD0FFFF;
    checks++;
    if (blk_valid !== 1'b0 || in_ready !== 1'b0 || word_count !== 5'd0) begin
      errors++;
      $display("FAIL bp_clear: got vld=%0b rdy=%0b wc=%0d want 0 0 0", blk_valid, in_ready, word_count);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || word_count !== 5'd0 || byte_count !== 7'd0 || blocks !== 384'h0) begin
      errors++;
      $display("FAIL bp_after_clear: got rdy=%0b wc=%0d bc=%0d want 1 0 0", in_ready, word_count, byte_count);
    end
    in_valid = 1'b0; in_last = 1'b0; blk_ack = 1'b0;
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 5; i++) send_word(32'h5000 + 32'(i), 1'b0, 3'd0);
    checks++;
    if (word_count !== 5'd5) begin
      errors++;
      $display("FAIL mid_pre_reset: wc got %0d want 5", word_count);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, blk_valid, finalize, word_count, byte_count} !== 15'h0 || blocks !== 384'h0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got rdy=%0b vld=%0b wc=%0d bc=%0d want all 0",
               in_ready, blk_valid, word_count, byte_count);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    wait_ready("mid_reset_ready");
    send_word(32'hDEADBEEF, 1'b1, 3'd4);
    checks++;
    if (blk_valid !== 1'b1 || word_count !== 5'd1 || byte_count !== 7'd4 || finalize !== 1'b1 ||
        blocks[31:0] !== 32'hDEADBEEF || blocks[383:32] !== 352'h0) begin
      errors++;
      $display("FAIL mid_new_msg: got vld=%0b wc=%0d bc=%0d fin=%0b w0=%h want 1 1 4 1 deadbeef",
               blk_valid, word_count, byte_count, finalize, blocks[31:0]);
    end
    blk_ack = 1'b1;
    repeat (2) @(negedge clk);
    blk_ack = 1'b0;
    wait_ready("mid_ack_ready");
  endtask

  task automatic test_full_and_last();
    logic [31:0] exp_last;
`ifdef BLOCK_LOADER_BYTE_MASK_EN
    exp_last = 32'h000000FF;
`else
    exp_last = 32'h123456FF;
`endif
    for (int i = 0; i < 11; i++) send_word(32'h100 + 32'(i), 1'b0, 3'd0);
    send_word(32'h123456FF, 1'b1, 3'd1);
    checks++;
    if (blk_valid !== 1'b1 || word_count !== 5'd12 || byte_count !== 7'd45 || finalize !== 1'b1) begin
      errors++;
      $display("FAIL full_last_counts: got vld=%0b wc=%0d bc=%0d fin=%0b want 1 12 45 1",
               blk_valid, word_count, byte_count, finalize);
    end
    checks++;
    if (blocks[383:352] !== exp_last || blocks[63:32] !== 32'h101) begin
      errors++;
      $display("FAIL full_last_blocks: got w11=%h w1=%h want %h 101", blocks[383:352], blocks[63:32], exp_last);
    end
    blk_ack = 1'b1;
    repeat (2) @(negedge clk);
    blk_ack = 1'b0;
    wait_ready("full_last_ready");
    send_word(32'h77777777, 1'b1, 3'd0);
    checks++;
    if (byte_count !== 7'd4 || word_count !== 5'd1 || finalize !== 1'b1 || blocks[31:0] !== 32'h77777777) begin
      errors++;
      $display("FAIL bytes_zero_full: got bc=%0d wc=%0d fin=%0b w0=%h want 4 1 1 77777777",
               byte_count, word_count, finalize, blocks[31:0]);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame_and_ack();
    test_short_frame_backpressure();
    test_mid_reset();
    test_full_and_last();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
